sdram_command_responder: RTL and testbench
==========================================

# sdram_command_responder

Responder end of the MusicBox SDRAM command handshake. The state controller's recording and playback states act as initiators on this handshake. This block accepts one read or write command at a time and issues it as a single Avalon-MM master transfer to the SDRAM controller core. It then reports completion back through `sdram_recievedCommand`, `sdram_isBusy`, `sdram_outputValid` and `sdram_readData`.

## Interface
Parameters:
- ADDR_WIDTH, 25, word address width (32M x16 SDRAM)
- DATA_WIDTH, 16, data word width
- TIMEOUT_CYCLES, 1024, maximum cycles a read waits for readdatavalid before abort

Ports:
- clock_50Mhz  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sdram_inputAddress  in  ADDR_WIDTH  command address, held stable by initiator while sdram_inputValid=1
- sdram_writeData  in  DATA_WIDTH  write data
- sdram_isWriting  in  1  1=write, 0=read
- sdram_inputValid  in  1  command request (level)
- sdram_recievedCommand  out  1  one-cycle pulse: command latched
- sdram_isBusy  out  1  command in progress
- sdram_outputValid  out  1  one-cycle pulse: sdram_readData valid
- sdram_readData  out  DATA_WIDTH  last read result, held until next read completes
- avm_address  out  ADDR_WIDTH  Avalon address
- avm_writedata  out  DATA_WIDTH  Avalon write data
- avm_read  out  1  Avalon read request
- avm_write  out  1  Avalon write request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_WIDTH  Avalon read data
- avm_readdatavalid  in  1  avm_readdata valid
- error_timeout  out  1  sticky: a read timed out

## Operation
- States: IDLE, ISSUE, WAIT_DATA.
- armed flag:
  - reset value 1
  - cleared when a command is accepted
  - set on any cycle in IDLE with sdram_inputValid=0
  - a request held high past completion is not re-accepted; the initiator must drop inputValid for at least one cycle between commands
- IDLE:
  - accepts when armed=1 and sdram_inputValid=1
  - on accept, latches address, writeData and isWriting into internal registers, then goes to ISSUE
  - never accepts a command in any other state
- ISSUE:
  - avm_address and avm_writedata are driven from the latched registers
  - avm_write=1 for a write, avm_read=1 for a read
  - held while avm_waitrequest=1
  - on the cycle avm_waitrequest=0:
    - write: go to IDLE
    - read with avm_readdatavalid=0: go to WAIT_DATA
    - read with avm_readdatavalid=1 in the same cycle: capture and complete directly
- WAIT_DATA:
  - avm_read=0
  - timeout counter increments each cycle
  - on avm_readdatavalid=1: sdram_readData <= avm_readdata, go to IDLE
  - when the counter reaches TIMEOUT_CYCLES-1 without readdatavalid: sdram_readData <= 0, error_timeout <= 1, go to IDLE
  - the counter clears on entry to WAIT_DATA
- sdram_isBusy = (state != IDLE), registered.
- Inputs sampled while busy are ignored. Stray avm_readdatavalid in IDLE or ISSUE-write is ignored.
- Reset (any time, including mid-transfer): state IDLE, armed=1, counter 0, error_timeout=0, all outputs 0 (including sdram_readData and avm_*). Outstanding Avalon transfers are abandoned.

## Timing
- Cycle A: IDLE, armed=1, inputValid=1 sampled.
- Cycle A+1:
  - sdram_recievedCommand=1 (this cycle only)
  - sdram_isBusy=1
  - avm_read or avm_write=1
- Write with waitrequest=0 at A+1: at A+2, isBusy=0 and avm_write=0. Minimum write occupancy is 1 busy cycle.
- Read accepted at A+1 (waitrequest=0) with readdatavalid at cycle R (R≥A+1):
  - at R+1: sdram_outputValid=1 for exactly one cycle, sdram_readData valid, sdram_isBusy=0
  - sdram_readData remains valid after the pulse
- Timeout: outputValid pulses exactly as for a normal read, with data 0x0000.
- sdram_outputValid never asserts for writes.
- Each accepted command produces exactly one recievedCommand pulse. At most one command is outstanding.
- Earliest next acceptance: the cycle after inputValid is seen low in IDLE. Back-to-back command issue rate is therefore at most one per 3 cycles plus slave latency.

## Test plan
- Write with zero wait states:
  - stimulus: addr=0x0000123, data=0xBEEF, isWriting=1, inputValid held 1 for 2 cycles
  - required: one recievedCommand pulse at A+1; avm_write=1 with address 0x0000123 and writedata 0xBEEF for 1 cycle; isBusy high 1 cycle; no outputValid
- Read with stalls and latency:
  - stimulus: addr=0x1FFFFFF; waitrequest=1 for 3 cycles; readdatavalid with 0xA5C3 2 cycles after acceptance
  - required: avm_read held through the stall; outputValid one cycle; readData=0xA5C3 and holds; isBusy falls the same cycle outputValid rises
- Held inputValid:
  - stimulus: inputValid held high across 3 completed-write windows
  - required: exactly one avm_write issued; a second write is issued only after inputValid drops for 1 cycle and rises again
- Timeout:
  - stimulus: TIMEOUT_CYCLES=16, no readdatavalid
  - required: outputValid at entry+16 cycles; readData=0x0000; error_timeout=1 and sticky; the next read completes normally with error_timeout still 1
- Reset mid-read:
  - stimulus: reset_n=0 in WAIT_DATA
  - required: all outputs 0 immediately (asynchronous); after release, a readdatavalid pulse is ignored and a new command is accepted normally
- Same-cycle data:
  - stimulus: waitrequest=0 and readdatavalid=1 with 0x0F0F in the first ISSUE cycle
  - required: outputValid next cycle with 0x0F0F; WAIT_DATA never entered

Source files
------------

// File: rtl/sdram_command_responder.sv
// -----------------------------------------------------------------------------
// sdram_command_responder
//
// Responder end of the MusicBox SDRAM command handshake. It accepts one read or
// write command at a time from the recording/playback initiators. It issues that
// command as a single Avalon-MM master transfer and reports completion back to
// the initiator.
//
// Ports:
//   clock_50Mhz            sole clock, rising edge
//   reset_n                asynchronous active-low reset
//   sdram_inputAddress     command word address (stable while inputValid=1)
//   sdram_writeData        write data
//   sdram_isWriting        1 = write, 0 = read
//   sdram_inputValid       level command request
//   sdram_recievedCommand  one-cycle pulse: command latched
//   sdram_isBusy           command in progress
//   sdram_outputValid      one-cycle pulse: sdram_readData valid
//   sdram_readData         last read result, held until next read completes
//   avm_*                  Avalon-MM master towards the SDRAM controller core
//   error_timeout          sticky: a read gave up waiting for readdatavalid
// -----------------------------------------------------------------------------
module sdram_command_responder #(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] sdram_inputAddress,
    input  logic [DATA_WIDTH-1:0] sdram_writeData,
    input  logic                  sdram_isWriting,
    input  logic                  sdram_inputValid,
    output logic                  sdram_recievedCommand,
    output logic                  sdram_isBusy,
    output logic                  sdram_outputValid,
    output logic [DATA_WIDTH-1:0] sdram_readData,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic [DATA_WIDTH-1:0] avm_writedata,
    output logic                  avm_read,
    output logic                  avm_write,
    input  logic                  avm_waitrequest,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  error_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;

    logic                  armed_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  is_write_r;
    logic                  recv_r;
    logic                  busy_r;
    logic                  ovalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [ADDR_WIDTH-1:0] avm_address_r;
    logic [DATA_WIDTH-1:0] avm_writedata_r;
    logic                  avm_read_r;
    logic                  avm_write_r;
    logic                  err_r;

    logic                  armed_nxt_s;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  is_write_nxt_s;
    logic                  recv_nxt_s;
    logic                  busy_nxt_s;
    logic                  ovalid_nxt_s;
    logic [DATA_WIDTH-1:0] rdata_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic [DATA_WIDTH-1:0] wdata_nxt_s;
    logic                  avm_read_nxt_s;
    logic                  avm_write_nxt_s;
    logic                  err_nxt_s;

    // A level request is only taken once per assertion: armed must be
    // re-established by seeing inputValid low while idle.
    logic accept_s;
    assign accept_s = (state_r == ST_IDLE) && armed_r && sdram_inputValid;

    assign sdram_recievedCommand = recv_r;
    assign sdram_isBusy          = busy_r;
    assign sdram_outputValid     = ovalid_r;
    assign sdram_readData        = rdata_r;
    assign avm_address           = avm_address_r;
    assign avm_writedata         = avm_writedata_r;
    assign avm_read              = avm_read_r;
    assign avm_write             = avm_write_r;
    assign error_timeout         = err_r;

    // State register.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (avm_waitrequest) begin
                    state_nxt_s = ST_ISSUE;
                end else if (is_write_r || avm_readdatavalid) begin
                    // Writes, and reads whose data returns with the
                    // accepting cycle, finish without visiting WAIT_DATA.
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (avm_readdatavalid || (cnt_r == CNT_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values for the datapath and every registered output.
    always_comb begin
        armed_nxt_s     = armed_r;
        cnt_nxt_s       = cnt_r;
        is_write_nxt_s  = is_write_r;
        addr_nxt_s      = avm_address_r;
        wdata_nxt_s     = avm_writedata_r;
        recv_nxt_s      = 1'b0;
        ovalid_nxt_s    = 1'b0;
        rdata_nxt_s     = rdata_r;
        err_nxt_s       = err_r;
        avm_read_nxt_s  = 1'b0;
        avm_write_nxt_s = 1'b0;
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (!sdram_inputValid) begin
                    armed_nxt_s = 1'b1;
                end else if (armed_r) begin
                    armed_nxt_s     = 1'b0;
                    recv_nxt_s      = 1'b1;
                    is_write_nxt_s  = sdram_isWriting;
                    addr_nxt_s      = sdram_inputAddress;
                    wdata_nxt_s     = sdram_writeData;
                    avm_write_nxt_s = sdram_isWriting;
                    avm_read_nxt_s  = ~sdram_isWriting;
                end else begin
                    armed_nxt_s = armed_r;
                end
            end
            ST_ISSUE: begin
                if (avm_waitrequest) begin
                    avm_read_nxt_s  = avm_read_r;
                    avm_write_nxt_s = avm_write_r;
                end else if (is_write_r) begin
                    // Write done; any readdatavalid seen here is stray.
                    cnt_nxt_s = cnt_r;
                end else if (avm_readdatavalid) begin
                    rdata_nxt_s  = avm_readdata;
                    ovalid_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            ST_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    rdata_nxt_s  = avm_readdata;
                    ovalid_nxt_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    // Give up: complete the read with zero data and flag it.
                    rdata_nxt_s  = '0;
                    ovalid_nxt_s = 1'b1;
                    err_nxt_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                armed_nxt_s = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            armed_r         <= 1'b1;
            cnt_r           <= '0;
            is_write_r      <= 1'b0;
            recv_r          <= 1'b0;
            busy_r          <= 1'b0;
            ovalid_r        <= 1'b0;
            rdata_r         <= '0;
            avm_address_r   <= '0;
            avm_writedata_r <= '0;
            avm_read_r      <= 1'b0;
            avm_write_r     <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            armed_r         <= armed_nxt_s;
            cnt_r           <= cnt_nxt_s;
            is_write_r      <= is_write_nxt_s;
            recv_r          <= recv_nxt_s;
            busy_r          <= busy_nxt_s;
            ovalid_r        <= ovalid_nxt_s;
            rdata_r         <= rdata_nxt_s;
            avm_address_r   <= addr_nxt_s;
            avm_writedata_r <= wdata_nxt_s;
            avm_read_r      <= avm_read_nxt_s;
            avm_write_r     <= avm_write_nxt_s;
            err_r           <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_sdram_command_responder.sv
module tb_sdram_command_responder;

    logic        clk;
    logic        rst_n;
    logic [24:0] addr;
    logic [15:0] wdata;
    logic        is_wr;
    logic        in_valid;
    logic        recv;
    logic        busy;
    logic        ovalid;
    logic [15:0] rdata;
    logic [24:0] avm_address;
    logic [15:0] avm_writedata;
    logic        avm_read;
    logic        avm_write;
    logic        waitreq;
    logic [15:0] avm_readdata;
    logic        rdv;
    logic        err;

    typedef struct {
        logic        wr;
        logic [24:0] a;
        logic [15:0] d;
    } avm_t;

    typedef struct {
        logic [15:0] d;
        logic        e;
    } rd_t;

    avm_t exp_avm[$];
    rd_t  exp_rd[$];
    int   checks   = 0;
    int   errors   = 0;
    int   exp_recv = 0;
    int   recv_seen = 0;

    sdram_command_responder #(
        .ADDR_WIDTH    (25),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock_50Mhz          (clk),
        .reset_n              (rst_n),
        .sdram_inputAddress   (addr),
        .sdram_writeData      (wdata),
        .sdram_isWriting      (is_wr),
        .sdram_inputValid     (in_valid),
        .sdram_recievedCommand(recv),
        .sdram_isBusy         (busy),
        .sdram_outputValid    (ovalid),
        .sdram_readData       (rdata),
        .avm_address          (avm_address),
        .avm_writedata        (avm_writedata),
        .avm_read             (avm_read),
        .avm_write            (avm_write),
        .avm_waitrequest      (waitreq),
        .avm_readdata         (avm_readdata),
        .avm_readdatavalid    (rdv),
        .error_timeout        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_avm(input logic wr, input logic [24:0] a, input logic [15:0] d);
        avm_t t;
        t.wr = wr;
        t.a  = a;
        t.d  = d;
        exp_avm.push_back(t);
        exp_recv++;
    endtask

    task automatic push_rd(input logic [15:0] d, input logic e);
        rd_t r;
        r.d = d;
        r.e = e;
        exp_rd.push_back(r);
    endtask

    // Monitor: every accepted Avalon transfer and every outputValid pulse is
    // matched against the next expected entry.
    always @(negedge clk) begin : monitor
        avm_t t;
        rd_t  r;
        if (rst_n) begin
            if ((avm_write || avm_read) && !waitreq) begin
                if (exp_avm.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL avm_unexpected: got transfer wr=%0d addr %0h, none expected at %0t",
                             avm_write, avm_address, $time);
                end else begin
                    t = exp_avm.pop_front();
                    chk("avm_is_write", 32'(avm_write), 32'(t.wr));
                    chk("avm_is_read", 32'(avm_read), 32'(!t.wr));
                    chk("avm_address", 32'(avm_address), 32'(t.a));
                    if (t.wr) chk("avm_writedata", 32'(avm_writedata), 32'(t.d));
                end
            end
            if (ovalid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ovalid_unexpected: got outputValid data %0h, none expected at %0t",
                             rdata, $time);
                end else begin
                    r = exp_rd.pop_front();
                    chk("read_data", 32'(rdata), 32'(r.d));
                    chk("read_err", 32'(err), 32'(r.e));
                    chk("busy_at_ovalid", 32'(busy), 32'h0);
                end
            end
            if (recv) recv_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; addr = '0; wdata = '0; is_wr = 1'b0; in_valid = 1'b0;
        waitreq = 1'b0; avm_readdata = '0; rdv = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_recv", 32'(recv), 32'h0);
        chk("rst_ovalid", 32'(ovalid), 32'h0);
        chk("rst_avm", 32'({avm_read, avm_write}), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        step();

        // Write, zero wait states, inputValid held two cycles.
        addr = 25'h0000123; wdata = 16'hBEEF; is_wr = 1'b1; in_valid = 1'b1;
        push_avm(1'b1, 25'h0000123, 16'hBEEF);
        step();
        chk("wr_recv", 32'(recv), 32'h1);
        chk("wr_busy", 32'(busy), 32'h1);
        chk("wr_avm_write", 32'(avm_write), 32'h1);
        step();
        chk("wr_recv_once", 32'(recv), 32'h0);
        chk("wr_busy_fall", 32'(busy), 32'h0);
        chk("wr_avm_write_fall", 32'(avm_write), 32'h0);
        in_valid = 1'b0;
        step();

        // Read with three stall cycles, data two cycles after acceptance.
        addr = 25'h1FFFFFF; is_wr = 1'b0; in_valid = 1'b1; waitreq = 1'b1;
        push_avm(1'b0, 25'h1FFFFFF, 16'h0000);
        push_rd(16'hA5C3, 1'b0);
        step();
        chk("rd_recv", 32'(recv), 32'h1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_stall_read", 32'(avm_read), 32'h1);
            step();
        end
        waitreq = 1'b0;
        chk("rd_read_held", 32'(avm_read), 32'h1);
        step();
        chk("rd_wait_read_low", 32'(avm_read), 32'h0);
        chk("rd_wait_busy", 32'(busy), 32'h1);
        step();
        rdv = 1'b1; avm_readdata = 16'hA5C3;
        step();
        chk("rd_ovalid", 32'(ovalid), 32'h1);
        rdv = 1'b0; avm_readdata = 16'h0000;
        step();
        chk("rd_ovalid_pulse", 32'(ovalid), 32'h0);
        chk("rd_data_hold", 32'(rdata), 32'hA5C3);

        // inputValid held high across several write windows: one write only.
        addr = 25'h00000AA; wdata = 16'h1111; is_wr = 1'b1; in_valid = 1'b1;
        push_avm(1'b1, 25'h00000AA, 16'h1111);
        step();
        chk("held_recv", 32'(recv), 32'h1);
        for (int i = 0; i < 8; i++) step();
        chk("held_idle_busy", 32'(busy), 32'h0);
        chk("held_no_write", 32'(avm_write), 32'h0);
        in_valid = 1'b0;
        step();
        addr = 25'h00000BB; wdata = 16'h2222; in_valid = 1'b1;
        push_avm(1'b1, 25'h00000BB, 16'h2222);
        step();
        chk("rearm_recv", 32'(recv), 32'h1);
        chk("rearm_write", 32'(avm_write), 32'h1);
        in_valid = 1'b0;
        step();
        step();

        // Read timeout (TIMEOUT_CYCLES=16), then a normal read.
        addr = 25'h0000456; is_wr = 1'b0; in_valid = 1'b1;
        push_avm(1'b0, 25'h0000456, 16'h0000);
        push_rd(16'h0000, 1'b1);
        step();
        in_valid = 1'b0;
        chk("to_err_before", 32'(err), 32'h0);
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_no_ovalid_early", 32'(ovalid), 32'h0);
        end
        step();
        chk("to_ovalid", 32'(ovalid), 32'h1);
        chk("to_data_zero", 32'(rdata), 32'h0);
        step();
        chk("to_err_sticky", 32'(err), 32'h1);
        addr = 25'h0000789; in_valid = 1'b1;
        push_avm(1'b0, 25'h0000789, 16'h0000);
        push_rd(16'h1234, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        rdv = 1'b1; avm_readdata = 16'h1234;
        step();
        rdv = 1'b0; avm_readdata = 16'h0000;
        chk("after_to_ovalid", 32'(ovalid), 32'h1);
        step();

        // Same-cycle data in the first ISSUE cycle.
        addr = 25'h0ABCDEF; in_valid = 1'b1;
        push_avm(1'b0, 25'h0ABCDEF, 16'h0000);
        push_rd(16'h0F0F, 1'b1);
        step();
        in_valid = 1'b0;
        rdv = 1'b1; avm_readdata = 16'h0F0F;
        chk("same_busy", 32'(busy), 32'h1);
        step();
        chk("same_ovalid", 32'(ovalid), 32'h1);
        chk("same_busy_fall", 32'(busy), 32'h0);
        // Stray readdatavalid while idle is ignored.
        avm_readdata = 16'hDEAD;
        step();
        rdv = 1'b0; avm_readdata = 16'h0000;
        step();
        chk("stray_idle_data", 32'(rdata), 32'h0F0F);

        // Reset in the middle of WAIT_DATA.
        addr = 25'h0000321; in_valid = 1'b1;
        push_avm(1'b0, 25'h0000321, 16'h0000);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_data", 32'(rdata), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_addr", 32'(avm_address), 32'h0);
        step();
        rst_n = 1'b1;
        rdv = 1'b1; avm_readdata = 16'h7777;
        step();
        rdv = 1'b0; avm_readdata = 16'h0000;
        step();
        chk("post_rst_data", 32'(rdata), 32'h0);
        addr = 25'h0000055; wdata = 16'h5A5A; is_wr = 1'b1; in_valid = 1'b1;
        push_avm(1'b1, 25'h0000055, 16'h5A5A);
        step();
        chk("post_rst_recv", 32'(recv), 32'h1);
        in_valid = 1'b0;
        step();
        step();

        chk("avm_queue_empty", 32'(exp_avm.size()), 32'h0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
        chk("recv_count", 32'(recv_seen), 32'(exp_recv));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
